// File: rtl/sweep_pkg.sv
// Shared types for the phase sweep sequencer: phase/dwell widths, config payload, FSM states.
package sweep_pkg;

    localparam int unsigned PHASE_BITS = 24;
    localparam int unsigned DWELL_BITS = 16;
    localparam int unsigned CFG_BITS   = 3 * PHASE_BITS + DWELL_BITS;

    typedef logic [PHASE_BITS-1:0] phase_t;
    typedef logic [DWELL_BITS-1:0] dwell_t;

    // First member lands in the MSBs, so start occupies the LSBs of config_in
    typedef struct packed {
        dwell_t dwell;
        phase_t step;
        phase_t stop;
        phase_t start;
    } sweep_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_DWELL = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/phase_sweep_gen.sv
// Linear frequency-sweep sequencer feeding dds phase increments.
// Optional PHASE_SWEEP_REPEAT_EN: loop the sweep forever and accept new configs at any time.
module phase_sweep_gen
    import sweep_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CFG_BITS-1:0]   config_in_data,
    input  logic                  config_in_valid,
    output logic                  config_in_ready,
    output logic [PHASE_BITS-1:0] phase_inc_out_data,
    output logic                  phase_inc_out_valid,
    input  logic                  phase_inc_out_ready,
    output logic                  busy_out,
    output logic                  done_out
);

    sweep_state_t state_q, state_d;
    sweep_cfg_t   cfg_q, cfg_d, cfg_in;
    phase_t       cur_q, cur_d;
    dwell_t       cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic         ready_q, ready_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         cfg_ok, out_ok, last;
    logic [PHASE_BITS:0] nxt;

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        cfg_in = sweep_cfg_t'(config_in_data);
        cfg_ok = config_in_valid && ready_q;
        out_ok = valid_q && phase_inc_out_ready;
        nxt    = {1'b0, cur_q} + {1'b0, cfg_q.step};
        last   = (cfg_q.step == '0) || nxt[PHASE_BITS] || (nxt > {1'b0, cfg_q.stop});

        case (state_q)
            ST_IDLE: begin
                if (cfg_ok) begin
                    cfg_d   = cfg_in;
                    cur_d   = cfg_in.start;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ok) begin
                    if (last) begin
                        done_d = 1'b1;
`ifdef PHASE_SWEEP_REPEAT_EN
                        cur_d = cfg_q.start;
                        if (cfg_q.dwell == '0) begin
                            state_d = ST_EMIT;
                        end else begin
                            state_d = ST_DWELL;
                            cnt_d   = cfg_q.dwell;
                        end
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        cur_d = nxt[PHASE_BITS-1:0];
                        if (cfg_q.dwell == '0) begin
                            state_d = ST_EMIT;
                        end else begin
                            state_d = ST_DWELL;
                            cnt_d   = cfg_q.dwell;
                        end
                    end
                end
            end
            ST_DWELL: begin
                // Counter was loaded with dwell, so EMIT resumes dwell cycles later
                cnt_d = cnt_q - DWELL_BITS'(1);
                if (cnt_q == DWELL_BITS'(1)) begin
                    state_d = ST_EMIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef PHASE_SWEEP_REPEAT_EN
        // A new config aborts whatever is running and wins over a coincident output handshake
        if (cfg_ok) begin
            cfg_d   = cfg_in;
            cur_d   = cfg_in.start;
            state_d = ST_EMIT;
            done_d  = 1'b0;
        end
        ready_d = 1'b1;
`else
        ready_d = (state_d == ST_IDLE);
`endif
        valid_d = (state_d == ST_EMIT);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign config_in_ready     = ready_q;
    assign phase_inc_out_data  = cur_q;
    assign phase_inc_out_valid = valid_q;
    assign busy_out            = busy_q;
    assign done_out            = done_q;

endmodule

// File: tb/tb_phase_sweep_gen.sv
// Randomized self-checking bench for phase_sweep_gen against a list-based sweep model.
module tb_phase_sweep_gen;
    import sweep_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [CFG_BITS-1:0]   config_in_data;
    logic                  config_in_valid;
    logic                  config_in_ready;
    logic [PHASE_BITS-1:0] phase_inc_out_data;
    logic                  phase_inc_out_valid;
    logic                  phase_inc_out_ready;
    logic                  busy_out;
    logic                  done_out;

    int total = 0;
    int bad   = 0;
    int wait_n;
    longint unsigned exp_q[$];

    always #5 clk = ~clk;

    phase_sweep_gen dut (
        .clk                 (clk),
        .reset               (reset),
        .config_in_data      (config_in_data),
        .config_in_valid     (config_in_valid),
        .config_in_ready     (config_in_ready),
        .phase_inc_out_data  (phase_inc_out_data),
        .phase_inc_out_valid (phase_inc_out_valid),
        .phase_inc_out_ready (phase_inc_out_ready),
        .busy_out            (busy_out),
        .done_out            (done_out)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic sweep_cfg_t mk(input longint unsigned start, input longint unsigned stop,
                                      input longint unsigned step, input longint unsigned dwell);
        sweep_cfg_t c;
        c.start = PHASE_BITS'(start);
        c.stop  = PHASE_BITS'(stop);
        c.step  = PHASE_BITS'(step);
        c.dwell = DWELL_BITS'(dwell);
        return c;
    endfunction

    // Expected value list: start, start+step, ... while within stop and the phase range
    task automatic build_exp(input sweep_cfg_t c);
        longint unsigned v, n;
        exp_q.delete();
        v = c.start;
        forever begin
            exp_q.push_back(v);
            n = v + c.step;
            if (c.step == 0 || n > 64'hFF_FFFF || n > c.stop) break;
            v = n;
        end
    endtask

    task automatic send_cfg(input sweep_cfg_t c);
        wait_n = 0;
        do begin
            @(negedge clk);
            wait_n++;
        end while (!config_in_ready && wait_n < 50);
        check("cfg_ready", config_in_ready, 1);
        config_in_data  = c;
        config_in_valid = 1'b1;
        @(posedge clk);
        #1 config_in_valid = 1'b0;
    endtask

    task automatic run_sweep(input sweep_cfg_t c, input bit rnd);
        int idx = 0;
        int cyc = 0;
        int last_ok = 0;
        bit prev_stall = 0;
        bit seen_valid = 0;
        longint unsigned prev_d = 0;
        build_exp(c);
        send_cfg(c);
        while (idx < exp_q.size() && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            phase_inc_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cyc == 1) begin
                check("first_valid", phase_inc_out_valid, 1);
                check("first_data", phase_inc_out_data, c.start);
            end
            check("busy", busy_out, 1);
            check("done_mid", done_out, 0);
            if (phase_inc_out_valid) begin
                check("data", phase_inc_out_data, exp_q[idx]);
                if (prev_stall) check("stable", phase_inc_out_data, prev_d);
                if (!seen_valid && idx > 0) check("gap", longint'(cyc - last_ok), longint'(c.dwell) + 1);
                seen_valid = 1;
                if (phase_inc_out_ready) begin
                    idx++;
                    last_ok    = cyc;
                    seen_valid = 0;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev_d     = phase_inc_out_data;
                end
            end else begin
                prev_stall = 0;
            end
        end
        check("sweep_len", idx, exp_q.size());
        @(negedge clk);
        check("done", done_out, 1);
        check("busy_end", busy_out, 0);
        check("ready_end", config_in_ready, 1);
        check("valid_end", phase_inc_out_valid, 0);
        @(negedge clk);
        check("done_pulse", done_out, 0);
        phase_inc_out_ready = 1'b1;
    endtask

    initial begin
        sweep_cfg_t c;
        int n;
        reset               = 1'b1;
        config_in_valid     = 1'b0;
        config_in_data      = '0;
        phase_inc_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", phase_inc_out_valid, 0);
        check("rst_data", phase_inc_out_data, 0);
        check("rst_busy", busy_out, 0);
        check("rst_done", done_out, 0);
        check("rst_ready", config_in_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("ready_after_rst", config_in_ready, 1);

`ifdef PHASE_SWEEP_REPEAT_EN
        begin
            int k = 0;
            int cyc = 0;
            send_cfg(mk('h100, 'h300, 'h100, 2));
            while (k < 7 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                if (phase_inc_out_valid) begin
                    check("rep_data", phase_inc_out_data, 'h100 * (k % 3 + 1));
                    k++;
                    @(negedge clk);
                    cyc++;
                    check("rep_done", done_out, (k % 3 == 0) ? 1 : 0);
                end
            end
            check("rep_count", k, 7);
            send_cfg(mk('h800, 'h900, 'h100, 0));
            @(negedge clk);
            check("abort_valid", phase_inc_out_valid, 1);
            check("abort_data", phase_inc_out_data, 'h800);
        end
`else
        // Basic and backpressured sweeps
        run_sweep(mk('h100, 'h400, 'h100, 3), 0);
        run_sweep(mk('h100, 'h400, 'h100, 3), 1);
        // Degenerate and overflow cases
        run_sweep(mk('h100, 'h400, 'h0, 2), 1);
        run_sweep(mk('h500, 'h100, 'h100, 1), 0);
        run_sweep(mk('hFFFF00, 'hFFFFFF, 'h80, 1), 1);

        // Reset during DWELL of the basic sweep
        send_cfg(mk('h100, 'h400, 'h100, 3));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(phase_inc_out_valid && phase_inc_out_ready) && n < 50);
        check("pre_rst_ok", phase_inc_out_valid, 1);
        @(negedge clk);
        check("pre_rst_dwell", phase_inc_out_valid, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", phase_inc_out_valid, 0);
        check("mid_rst_busy", busy_out, 0);
        check("mid_rst_done", done_out, 0);
        check("mid_rst_data", phase_inc_out_data, 0);
        run_sweep(mk('h200, 'h500, 'h180, 0), 0);
        check("rst_accept_wait", wait_n, 1);

        // Random configurations under random backpressure
        for (int t = 0; t < 8; t++) begin
            longint unsigned lim;
            c.start = PHASE_BITS'($urandom);
            c.step  = PHASE_BITS'($urandom_range(0, 'h20000));
            c.dwell = DWELL_BITS'($urandom_range(0, 4));
            lim = longint'(c.start) + longint'($urandom_range(0, 8)) * c.step
                  + longint'($urandom_range(0, 'h100));
            c.stop = (lim > 64'hFF_FFFF) ? PHASE_BITS'('hFF_FFFF) : PHASE_BITS'(lim);
            if ($urandom_range(0, 4) == 0 && c.start != 0) c.stop = c.start - PHASE_BITS'(1);
            run_sweep(c, 1);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sweep_gen.md
# phase_sweep_gen

Programmable linear frequency-sweep sequencer that drives the `phase_inc_in` stream of `dds`. It accepts one sweep configuration over AXI-stream: start, stop, step and dwell. It then emits phase increments start, start+step, … up to stop, holding each one for a programmable dwell time. This provides stepped-tone and chirp stimulus without processor involvement.

## Interface
- `PHASE_BITS`, 24: width of one phase increment; must match `dds.PHASE_BITS`.
- `DWELL_BITS`, 16: width of the dwell count, in clk cycles.
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `config_in`  Axis_If slave  3*PHASE_BITS+DWELL_BITS: sweep configuration. Packing, LSB first:
  - start `[P-1:0]`
  - stop `[2P-1:P]`
  - step `[3P-1:2P]`
  - dwell `[3P+D-1:3P]`
- `phase_inc_out`  Axis_If master  PHASE_BITS: phase increment stream toward `dds`.
- `busy_out`  out  1: high while a sweep is in progress.
- `done_out`  out  1: one-cycle pulse when the sweep completes.

## Operation
- States:
  - IDLE: `config_in.ready`=1.
  - EMIT: `phase_inc_out.valid`=1, holding `cur`.
  - DWELL: counting.
- IDLE → EMIT on `config_in.ok`. Latch all fields; set `cur` = start.
- EMIT:
  - Hold data stable while valid && !ready.
  - On `phase_inc_out.ok`, compute `nxt` = {1'b0,cur} + {1'b0,step`}` (PHASE_BITS+1 wide).
  - If step==0, or `nxt[PHASE_BITS]`=1, or `nxt` > stop (unsigned): the current value is the last one. Go to IDLE and pulse `done_out`.
  - Otherwise set `cur` = `nxt` and go to DWELL with the counter loaded to dwell.
- DWELL: decrement each cycle. When the counter reaches 0, go to EMIT. With dwell==0, go straight from EMIT to EMIT: valid stays high and data changes the cycle after `ok`.
- start > stop: emit start once, then done.
- `busy_out` = (state != IDLE).
- `config_in.ready` is low outside IDLE, except as given under Configuration.

## Timing
- Reset values: state IDLE; `phase_inc_out.valid`=0; `phase_inc_out.data`=0; `config_in.ready`=0 while reset is asserted and 1 from the first cycle after; `busy_out`=0; `done_out`=0.
- `config_in.ok` at cycle N: `phase_inc_out.valid`=1 with data=start at N+1.
- `phase_inc_out.ok` at cycle M, not last: next value presented valid at M+dwell+1.
- Final `ok` at cycle M: `done_out`=1 and `config_in.ready`=1 at M+1; `busy_out`=0 at M+1.
- A new config may be accepted at M+1, so `done_out` and `config_in.ok` can coincide.
- Reset mid-sweep takes effect on the next edge:
  - valid drops and data clears.
  - No `done_out` pulse.
  - The partial sweep is discarded.
- All outputs are registered; there is no combinational path from `phase_inc_out.ready` to data.

## Configuration
- Macro: `PHASE_SWEEP_REPEAT_EN`.
- Defined:
  - After the final value, reload `cur` = start and enter DWELL instead of IDLE. The sweep loops indefinitely.
  - `done_out` pulses at each wrap.
  - `config_in.ready`=1 in every state. A `config_in.ok` in EMIT or DWELL aborts the current sweep and restarts with the new config, with the same N+1 timing.
  - If `config_in.ok` and `phase_inc_out.ok` coincide, the new config wins.
- Undefined: one-shot behaviour as above; `config_in.ready` only in IDLE.

## Structure
- `sweep_pkg` holds:
  - `phase_t` (logic [PHASE_BITS-1:0])
  - `dwell_t`
  - packed struct `sweep_cfg_t` {dwell, step, stop, start}, matching the `config_in` packing
  - state enum `sweep_state_t`
- Single module. The dwell counter and adder are inline; no sub-module.

## Test plan
- Basic sweep: start=0x000100, stop=0x000400, step=0x000100, dwell=3, ready always 1.
  - Expect outputs 0x100, 0x200, 0x300, 0x400 on `ok` cycles spaced 4 apart.
  - Expect `done_out` one cycle after the 0x400 `ok`; `busy_out` high throughout.
- Backpressure: same config with random `phase_inc_out.ready`.
  - Expect an identical value sequence.
  - Data stable whenever valid && !ready.
  - Gap between value k's `ok` and value k+1's first valid equals 4 cycles.
- Degenerate: step=0 → single output start, then done. start=0x000500, stop=0x000100 → single output 0x500, then done.
- Overflow: start=0xFFFF00, stop=0xFFFFFF, step=0x000080.
  - Expect outputs 0xFFFF00, 0xFFFF80, then done.
  - 0x000000 is never emitted.
- Reset: assert reset for 1 cycle during DWELL of the basic sweep.
  - Next cycle: valid=0, `busy_out`=0, no `done_out`.
  - A new config is accepted the following cycle.
- `PHASE_SWEEP_REPEAT_EN`, config 0x100..0x300 step 0x100 dwell 2.
  - Expect sequence 0x100, 0x200, 0x300, 0x100, … with `done_out` at each wrap.
  - New config 0x800/0x900/0x100/0 issued during DWELL: next output 0x800.
